// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship score timer: FSM encodings and BCD limits.
package nexys_starship_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int          BCD_DIGITS = 4;
  localparam logic [15:0] BCD_MAX    = 16'h9999;

endpackage

// File: rtl/nexys_starship_score_timer_bcd_digit_counter.sv
// One BCD digit (0..9) with increment enable and synchronous clear.
// carry is asserted when the digit is at 9 and being incremented, so digits
// can be chained as a ripple-enable counter.
module bcd_digit_counter (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc && (digit == 4'd9);

  // Digit register: clear wins, otherwise count 0..9 and roll over.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset)      digit <= 4'd0;
    else if (clr)   digit <= 4'd0;
    else if (inc)   digit <= carry ? 4'd0 : digit + 4'd1;
  end

endmodule

// File: rtl/nexys_starship_score_timer.sv
// Survival-time score counter for the starship game.
// Counts whole prescaled ticks while in Play as 4-digit BCD, freezes on game
// over and keeps the session high score. Optional blink of the score digits
// in OVER is enabled with the macro STARSHIP_SCORE_BLINK_EN.
module nexys_starship_score_timer
  import nexys_starship_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int PRESC_W  = 27
) (
  input  logic        board_clk,
  input  logic        Reset,
  input  logic        play_flag,
  input  logic        gameover_ctrl,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic        running,
  output logic        tick,
  output logic        new_high,
  output logic        score_blank
);

  localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 1);
`ifdef STARSHIP_SCORE_BLINK_EN
  localparam logic [PRESC_W-1:0] BLINK_TOP = PRESC_W'(TICK_DIV / 2 - 1);
`endif

  state_t                          state, state_nx;
  logic [PRESC_W-1:0]              presc;
  logic                            tick_hit;
  logic                            score_sat;
  logic                            score_clr;
  logic                            over_first;
  logic [BCD_DIGITS-1:0]           inc_d;
  logic [BCD_DIGITS-1:0]           carry_d;
  logic [BCD_DIGITS-1:0][3:0]      digits;

  // State register.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (play_flag && !gameover_ctrl)  state_nx = ST_RUN;
      ST_RUN:  if (gameover_ctrl || !play_flag)  state_nx = ST_OVER;
      ST_OVER: if (!play_flag && !gameover_ctrl) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // A tick only counts if the game is still running on that cycle, so a
  // coincident game end suppresses both the increment and the pulse.
  assign tick_hit  = (state == ST_RUN) && (state_nx == ST_RUN) && (presc == PRESC_TOP);
  assign score_sat = (score_bcd == BCD_MAX);
  assign score_clr = (state_nx == ST_IDLE);

  // Prescaler restarts on every state entry; wraps at TICK_DIV-1 in RUN.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset)                           presc <= '0;
    else if (state_nx != state)          presc <= '0;
    else if (state == ST_RUN)            presc <= (presc == PRESC_TOP) ? '0 : presc + PRESC_W'(1);
`ifdef STARSHIP_SCORE_BLINK_EN
    else if (state == ST_OVER)           presc <= (presc == BLINK_TOP) ? '0 : presc + PRESC_W'(1);
`endif
    else                                 presc <= '0;
  end

  // Ripple-enable digit chain; the least significant digit is gated at 9999.
  assign inc_d[0] = tick_hit && !score_sat;
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    if (i > 0) begin : g_chain
      assign inc_d[i] = carry_d[i-1];
    end
    bcd_digit_counter u_digit (
      .board_clk (board_clk),
      .Reset     (Reset),
      .inc       (inc_d[i]),
      .clr       (score_clr),
      .digit     (digits[i]),
      .carry     (carry_d[i])
    );
  end
  assign score_bcd = digits;

  // Saturation gating means the top digit can never carry out.
  always_ff @(posedge board_clk) begin
    if (!Reset) assert (!carry_d[BCD_DIGITS-1]);
  end

  // Registered status pulses and OVER entry marker.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      running    <= 1'b0;
      tick       <= 1'b0;
      over_first <= 1'b0;
    end else begin
      running    <= (state_nx == ST_RUN);
      tick       <= tick_hit;
      over_first <= (state != ST_OVER) && (state_nx == ST_OVER);
    end
  end

  // High score is compared during the first OVER cycle (score already frozen).
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      high_bcd <= 16'h0000;
      new_high <= 1'b0;
    end else if (over_first && (score_bcd > high_bcd)) begin
      high_bcd <= score_bcd;
      new_high <= 1'b1;
    end else begin
      new_high <= 1'b0;
    end
  end

`ifdef STARSHIP_SCORE_BLINK_EN
  // Blink the score digits in OVER every TICK_DIV/2 cycles, starting dark-off.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset)                                      score_blank <= 1'b0;
    else if (state != ST_OVER || state_nx != ST_OVER) score_blank <= 1'b0;
    else if (presc == BLINK_TOP)                    score_blank <= ~score_blank;
  end
`else
  assign score_blank = 1'b0;
`endif

endmodule

// File: tb/tb_nexys_starship_score_timer.sv
// Scoreboard bench for the starship score timer (TICK_DIV = 4).
module tb_nexys_starship_score_timer;

  localparam int TD = 4;

  logic        board_clk = 1'b0;
  logic        Reset;
  logic        play_flag;
  logic        gameover_ctrl;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic        running;
  logic        tick;
  logic        new_high;
  logic        score_blank;

  nexys_starship_score_timer #(.TICK_DIV(TD), .PRESC_W(3)) dut (
    .board_clk     (board_clk),
    .Reset         (Reset),
    .play_flag     (play_flag),
    .gameover_ctrl (gameover_ctrl),
    .score_bcd     (score_bcd),
    .high_bcd      (high_bcd),
    .running       (running),
    .tick          (tick),
    .new_high      (new_high),
    .score_blank   (score_blank)
  );

  always #5 board_clk = ~board_clk;

  int cyc = 0;
  always @(posedge board_clk) cyc <= cyc + 1;

  typedef struct { int c; logic [15:0] v; } ev_t;
  ev_t tick_q[$];
  ev_t nh_q[$];
  ev_t mon_e;

  int ntests = 0;
  int nfail  = 0;
  bit chk_en = 1'b0;
  int run_lo = 1, run_hi = 0;
  int over_lo = 1, over_hi = 0;
  int high_m = 0;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge board_clk);
    #1;
  endtask

  // Monitor: pops expected events whenever the DUT pulses, checks levels.
  always @(negedge board_clk) begin
    if (chk_en) begin
      if (tick) begin
        if (tick_q.size() == 0) chk("tick with nothing expected", tick, 1'b0);
        else begin
          mon_e = tick_q.pop_front();
          chk("tick cycle", cyc, mon_e.c);
          chk("score at tick", score_bcd, mon_e.v);
        end
      end else if (tick_q.size() != 0 && tick_q[0].c <= cyc) begin
        chk("missed tick", tick, 1'b1);
        void'(tick_q.pop_front());
      end
      if (new_high) begin
        if (nh_q.size() == 0) chk("new_high with nothing expected", new_high, 1'b0);
        else begin
          mon_e = nh_q.pop_front();
          chk("new_high cycle", cyc, mon_e.c);
          chk("high at new_high", high_bcd, mon_e.v);
        end
      end else if (nh_q.size() != 0 && nh_q[0].c <= cyc) begin
        chk("missed new_high", new_high, 1'b1);
        void'(nh_q.pop_front());
      end
      chk("running", running, (cyc >= run_lo && cyc <= run_hi) ? 1 : 0);
`ifdef STARSHIP_SCORE_BLINK_EN
      chk("score_blank", score_blank,
          (cyc >= over_lo && cyc <= over_hi) ? (((cyc - over_lo) / (TD / 2)) % 2) : 0);
`else
      chk("score_blank", score_blank, 1'b0);
`endif
    end
  end

  // One game: play held p cycles, ended by method m, OVER held h cycles.
  // Ticks land every TD cycles after RUN entry; one landing on the end cycle is lost.
  task automatic run_game(input int p, input int m, input int h);
    int c, t, fin;
    ev_t e;
    c = cyc;
    play_flag = 1'b1;
    gameover_ctrl = 1'b0;
    run_lo = c + 1;
    run_hi = c + p;
    over_lo = c + p + 1;
    over_hi = c + p + h;
    t = (p - 1) / TD;
    for (int j = 1; j <= t; j++) begin
      e.c = c + 1 + TD * j;
      e.v = to_bcd(j > 9999 ? 9999 : j);
      tick_q.push_back(e);
    end
    fin = (t > 9999) ? 9999 : t;
    if (fin > high_m) begin
      e.c = c + p + 2;
      e.v = to_bcd(fin);
      nh_q.push_back(e);
      high_m = fin;
    end
    repeat (p) step();
    case (m)
      0:       begin play_flag = 1'b1; gameover_ctrl = 1'b1; end
      1:       begin play_flag = 1'b0; gameover_ctrl = 1'b1; end
      default: begin play_flag = 1'b0; gameover_ctrl = 1'b0; end
    endcase
    step();
    for (int k = 1; k < h; k++) begin
      play_flag = 1'($urandom_range(0, 1));
      gameover_ctrl = 1'b1;
      step();
    end
    chk("frozen score in OVER", score_bcd, to_bcd(fin));
    play_flag = 1'b0;
    gameover_ctrl = 1'b0;
    step();
    chk("score cleared in IDLE", score_bcd, 16'h0000);
    chk("high score", high_bcd, to_bcd(high_m));
    step();
    chk("ticks outstanding", tick_q.size(), 0);
    chk("new_high outstanding", nh_q.size(), 0);
  endtask

  task automatic pulse_reset();
    chk_en = 1'b0;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    tick_q.delete();
    nh_q.delete();
    high_m = 0;
    run_lo = 1; run_hi = 0; over_lo = 1; over_hi = 0;
    step();
    chk_en = 1'b1;
  endtask

  initial begin
    int c;
    ev_t e;
    Reset = 1'b1;
    play_flag = 1'b0;
    gameover_ctrl = 1'b0;
    step();
    step();
    chk("reset score", score_bcd, 16'h0000);
    chk("reset high", high_bcd, 16'h0000);
    chk("reset running", running, 1'b0);
    chk("reset tick", tick, 1'b0);
    chk("reset new_high", new_high, 1'b0);
    chk("reset blank", score_blank, 1'b0);
    Reset = 1'b0;
    step();
    chk_en = 1'b1;

    // 10 ticks with carry 0009 -> 0010.
    run_game(41, 0, 3);
    pulse_reset();
    // Game over lands exactly on tick 8: score stays 7.
    run_game(32, 0, 2);
    // Equal score: no update.
    run_game(29, 1, 1);
    // Lower score: no update.
    run_game(21, 2, 3);

    // Asynchronous reset mid-RUN at score 3, high 7.
    c = cyc;
    play_flag = 1'b1;
    gameover_ctrl = 1'b0;
    run_lo = c + 1;
    run_hi = c + 1000;
    for (int j = 1; j <= 3; j++) begin
      e.c = c + 1 + TD * j;
      e.v = to_bcd(j);
      tick_q.push_back(e);
    end
    repeat (2 + 3 * TD) step();
    chk("score before async reset", score_bcd, 16'h0003);
    chk("high before async reset", high_bcd, 16'h0007);
    chk("ticks before async reset", tick_q.size(), 0);
    chk_en = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("async reset score", score_bcd, 16'h0000);
    chk("async reset high", high_bcd, 16'h0000);
    chk("async reset running", running, 1'b0);
    chk("async reset tick", tick, 1'b0);
    chk("async reset new_high", new_high, 1'b0);
    play_flag = 1'b0;
    step();
    Reset = 1'b0;
    tick_q.delete();
    nh_q.delete();
    high_m = 0;
    run_lo = 1; run_hi = 0; over_lo = 1; over_hi = 0;
    step();
    chk_en = 1'b1;

    // Randomized games.
    for (int g = 0; g < 12; g++) begin
      run_game($urandom_range(2, 120), $urandom_range(0, 2), $urandom_range(1, 6));
      repeat ($urandom_range(0, 3)) step();
    end

    // 0099 -> 0100, then saturation at 9999 with two extra ticks.
    run_game(TD * 100 + 1, 0, 2);
    run_game(TD * 10001 + 1, 0, 4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/nexys_starship_score_timer.md
Name: nexys_starship_score_timer

Overview:
Survival-time score counter for the starship game.
- Consumes the game-level play_flag and the combined gameover_ctrl.
- Counts elapsed play time in whole ticks as 4-digit BCD, freezes the count on game over, and keeps a session high score.
- Its BCD digits feed the top-level SSD mux (score on SSD5..SSD2, high on SSD7..SSD6 upper digits). It runs on the full-rate board clock with an internal prescaler.

Parameters:
- TICK_DIV, 100000000, board_clk cycles per score increment (1 s at 100 MHz); legal range 2..2^27-1.
- PRESC_W, 27, prescaler counter width; must satisfy 2^PRESC_W > TICK_DIV-1.

Ports:
- board_clk  in  1  system clock, 100 MHz
- Reset  in  1  asynchronous, active-high; clock board_clk
- play_flag  in  1  level, high while the game SM is in Play
- gameover_ctrl  in  1  level, high when any monster/game-over condition is active
- score_bcd  out  16  current score, 4 BCD digits, [15:12] most significant
- high_bcd  out  16  best score since Reset, 4 BCD digits
- running  out  1  high in RUN state
- tick  out  1  one-cycle pulse on each score increment
- new_high  out  1  one-cycle pulse when high_bcd is updated
- score_blank  out  1  SSD blank request for score digits (see Optional Feature)

Behaviour:
- Reset (async): state=IDLE; prescaler=0; score_bcd=0; high_bcd=0; running=0; tick=0; new_high=0; score_blank=0.
- States (2-bit): IDLE=0, RUN=1, OVER=2; encoding 3 is illegal and returns to IDLE on the next clock.
- IDLE:
  - score_bcd holds 0.
  - play_flag=1 and gameover_ctrl=0 -> RUN next cycle, prescaler cleared.
- RUN:
  - running=1.
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - On the cycle the prescaler equals TICK_DIV-1: tick=1 and score_bcd increments by 1 in BCD (digit 9 -> 0 with carry into the next digit).
  - The first tick occurs exactly TICK_DIV cycles after entering RUN.
- Saturation: at 9999 the score holds at 9999. tick still pulses; digits do not wrap.
- gameover_ctrl=1 in RUN -> OVER next cycle.
  - gameover_ctrl has priority over a coincident tick: no increment, tick=0 on that cycle.
- play_flag=0 in RUN (without game over) -> OVER. This is treated as game end.
- OVER:
  - Entry cycle: if score_bcd > high_bcd (unsigned compare of the 16-bit BCD value, valid since BCD ordering is preserved), then high_bcd <= score_bcd and new_high pulses 1 cycle, one cycle after entry.
  - Equal score: no update, no pulse.
  - score_bcd is frozen.
  - Leaves to IDLE when play_flag=0 and gameover_ctrl=0. score_bcd clears on the IDLE entry edge.
- Outputs are registered; no combinational paths from inputs to outputs.
- Reset mid-RUN clears everything including high_bcd.
- The inputs are already synchronous to board_clk; no synchronizers are required.

Optional Feature:
- Macro STARSHIP_SCORE_BLINK_EN.
- When defined:
  - In OVER, score_blank toggles every TICK_DIV/2 cycles, reusing the prescaler, which restarts at OVER entry. The first toggle to 1 occurs TICK_DIV/2 cycles after entry.
  - score_blank is forced to 0 in IDLE and RUN.
- When undefined: score_blank is tied 0 and no extra logic is generated.

Decomposition:
- Shared package nexys_starship_pkg holds:
  - state encodings ST_IDLE/ST_RUN/ST_OVER;
  - BCD_DIGITS=4;
  - BCD_MAX=16'h9999.
- Sub-module bcd_digit_counter: one 4-bit BCD digit with inputs inc, clr and outputs digit, carry (carry asserted when digit=9 and inc).
  - Instantiated 4 times in a ripple-enable chain.
  - Saturation is handled in the parent by gating inc at 9999.

Test Plan (TICK_DIV overridden to 4):
- Reset, then play_flag=1 for 41 cycles -> state RUN 1 cycle later; tick every 4 cycles; score_bcd=16'h0010 after 10 ticks (BCD carry checked at 0009->0010).
- Run to 0099 then one more tick -> 16'h0100. Force the counter to 9998, tick twice -> holds 16'h9999, tick still pulses.
- Score 0007, assert gameover_ctrl on the exact tick cycle -> score stays 0007, tick=0, OVER next cycle, high_bcd=0007, new_high pulses once.
- Second game reaching 0005, then game over -> high_bcd stays 0007, no new_high. Release play_flag and gameover_ctrl -> IDLE, score_bcd=0.
- Assert Reset asynchronously mid-RUN with score 0003 and high 0007 -> all outputs 0 immediately, state IDLE.
- With STARSHIP_SCORE_BLINK_EN in OVER -> score_blank toggles every 2 cycles. Without it -> score_blank constant 0.
